multicycle_control: RTL

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control.sv
// Control FSM for a multicycle MIPS-subset datapath with a shared instruction/data memory.
// Control outputs are decoded from the current state, with a handshake on MemReady.
module multicycle_control (
    input  logic       Clk,
    input  logic       Reset,
    input  logic [5:0] Op,
    input  logic [5:0] Funct,
    input  logic       Zero,
    input  logic       MemReady,
    output logic       IorD,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSrc,
    output logic [2:0] ALUControl,
    output logic       PCEn,
    output logic       IllegalOp,
    output logic [3:0] State
);

    localparam int unsigned OP_W  = 6;
    localparam int unsigned ALU_W = 3;

    localparam logic [OP_W-1:0] OP_RTYPE = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW    = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW    = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ   = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI  = 6'b001000;
    localparam logic [OP_W-1:0] OP_J     = 6'b000010;

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;

    localparam logic [ALU_W-1:0] ALU_AND = 3'b000;
    localparam logic [ALU_W-1:0] ALU_OR  = 3'b001;
    localparam logic [ALU_W-1:0] ALU_ADD = 3'b010;
    localparam logic [ALU_W-1:0] ALU_SUB = 3'b110;
    localparam logic [ALU_W-1:0] ALU_SLT = 3'b111;

    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        EXECUTE = 4'd6,
        ALUWB   = 4'd7,
        BEQ     = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JUMP    = 4'd11
    } state_t;

    typedef enum logic [1:0] {
        ALUOP_NONE,
        ALUOP_ADD,
        ALUOP_SUB,
        ALUOP_FUNCT
    } aluop_t;

    state_t           state_q;
    state_t           state_d;
    aluop_t           alu_op;
    logic             pc_write;
    logic             branch;
    logic             mem_write_raw;
    logic             reg_write_raw;
    logic             ir_write_raw;
    logic             illegal_raw;
    logic             funct_ok;
    logic [ALU_W-1:0] funct_ctl;

    always_ff @(posedge Clk) begin
        if (Reset) state_q <= FETCH;
        else       state_q <= state_d;
    end

    // R-type function decode; unknown functs yield no operation and are flagged illegal
    always_comb begin
        funct_ok  = 1'b1;
        funct_ctl = ALU_AND;
        case (Funct)
            FN_ADD:  funct_ctl = ALU_ADD;
            FN_SUB:  funct_ctl = ALU_SUB;
            FN_AND:  funct_ctl = ALU_AND;
            FN_OR:   funct_ctl = ALU_OR;
            FN_SLT:  funct_ctl = ALU_SLT;
            default: funct_ok  = 1'b0;
        endcase
    end

    always_comb begin
        state_d       = state_q;
        IorD          = 1'b0;
        mem_write_raw = 1'b0;
        ir_write_raw  = 1'b0;
        RegDst        = 1'b0;
        MemtoReg      = 1'b0;
        reg_write_raw = 1'b0;
        ALUSrcA       = 1'b0;
        ALUSrcB       = 2'b00;
        PCSrc         = 2'b00;
        alu_op        = ALUOP_NONE;
        pc_write      = 1'b0;
        branch        = 1'b0;
        illegal_raw   = 1'b0;
        case (state_q)
            FETCH: begin
                ALUSrcB = 2'b01;
                alu_op  = ALUOP_ADD;
                if (MemReady) begin
                    ir_write_raw = 1'b1;
                    pc_write     = 1'b1;
                    state_d      = DECODE;
                end
            end
            DECODE: begin
                ALUSrcB = 2'b11;
                alu_op  = ALUOP_ADD;
                case (Op)
                    OP_LW, OP_SW: state_d = MEMADR;
                    OP_RTYPE:     state_d = EXECUTE;
                    OP_BEQ:       state_d = BEQ;
                    OP_ADDI:      state_d = ADDIEX;
                    OP_J:         state_d = JUMP;
                    default: begin
                        illegal_raw = 1'b1;
                        state_d     = FETCH;
                    end
                endcase
            end
            MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                alu_op  = ALUOP_ADD;
                state_d = (Op == OP_SW) ? MEMWR : MEMRD;
            end
            MEMRD: begin
                IorD = 1'b1;
                if (MemReady) state_d = MEMWB;
            end
            MEMWB: begin
                MemtoReg      = 1'b1;
                reg_write_raw = 1'b1;
                state_d       = FETCH;
            end
            MEMWR: begin
                IorD          = 1'b1;
                mem_write_raw = 1'b1;
                if (MemReady) state_d = FETCH;
            end
            EXECUTE: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_FUNCT;
                if (funct_ok) begin
                    state_d = ALUWB;
                end else begin
                    illegal_raw = 1'b1;
                    state_d     = FETCH;
                end
            end
            ALUWB: begin
                RegDst        = 1'b1;
                reg_write_raw = 1'b1;
                state_d       = FETCH;
            end
            BEQ: begin
                ALUSrcA = 1'b1;
                alu_op  = ALUOP_SUB;
                PCSrc   = 2'b01;
                branch  = 1'b1;
                state_d = FETCH;
            end
            ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                alu_op  = ALUOP_ADD;
                state_d = ADDIWB;
            end
            ADDIWB: begin
                reg_write_raw = 1'b1;
                state_d       = FETCH;
            end
            JUMP: begin
                PCSrc    = 2'b10;
                pc_write = 1'b1;
                state_d  = FETCH;
            end
            default: state_d = FETCH;
        endcase
    end

    always_comb begin
        ALUControl = ALU_AND;
        case (alu_op)
            ALUOP_ADD:   ALUControl = ALU_ADD;
            ALUOP_SUB:   ALUControl = ALU_SUB;
            ALUOP_FUNCT: ALUControl = funct_ctl;
            default:     ALUControl = ALU_AND;
        endcase
    end

    // Side-effecting strobes are suppressed for as long as reset is held
    assign MemWrite  = mem_write_raw & ~Reset;
    assign RegWrite  = reg_write_raw & ~Reset;
    assign IRWrite   = ir_write_raw  & ~Reset;
    assign IllegalOp = illegal_raw   & ~Reset;
    assign PCEn      = (pc_write | (branch & Zero)) & ~Reset;
    assign State     = state_q;

endmodule
